// File: rtl/usb_rx_decoder_pkg.sv
// USB full-speed receive decoder shared types.
// Line levels, receiver states and default timing.
package usb_rx_decoder_pkg;

  localparam logic LINE_J = 1'b1;
  localparam logic LINE_K = 1'b0;

  localparam int CLKS_PER_BIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    EOP
  } rx_state_t;

endpackage

// File: rtl/usb_dpll.sv
// Digital clock recovery for the USB receive path.
// Edges resync the phase; strobe marks the bit centre.
module usb_dpll #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic se0,
  output logic strobe
);

  localparam int PW = $clog2(CLKS_PER_BIT);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase;
  logic          d_q;
  logic          edge_det;

  // An edge forces phase 0 this cycle, so it also masks a strobe.
  always_comb begin
    edge_det = (d != d_q) && !se0;
    phase    = edge_det ? '0 : phase_q;
    strobe   = (phase == PW'(CLKS_PER_BIT / 2));
  end

  // Phase counter and previous line level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
      d_q     <= 1'b1;
    end else begin
      d_q <= d;
      if (phase == PW'(CLKS_PER_BIT - 1))
        phase_q <= '0;
      else
        phase_q <= phase + PW'(1);
    end
  end

endmodule

// File: rtl/usb_rx_decoder.sv
// USB receive decoder: NRZI, SYNC, unstuffing, EOP.
// Emits a strobed bit stream with framing and errors.
module usb_rx_decoder
  import usb_rx_decoder_pkg::*;
#(
  parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEF,
  parameter int STUFF_LEN      = 6,
  parameter int SYNC_MIN_ZEROS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  input  logic se0,
  output logic rx_valid,
  output logic rx_data,
  output logic rx_active,
  output logic eop,
  output logic rx_error
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);

  rx_state_t state_q, state_d;
  logic          level_q, level_d;
  logic          d_q;
  logic [OW-1:0] ones_q, ones_d;
  logic [ZW-1:0] zeros_q, zeros_d;
  logic          valid_d, data_d, active_d;
  logic          eop_d, err_d;
  logic          strobe;
  logic          bit_dec;
  logic          k_edge;
  logic          ones_full;

  usb_dpll #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_dpll (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (d),
    .se0   (se0),
    .strobe(strobe)
  );

  // Next state, counters and output values.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    ones_d    = ones_q;
    zeros_d   = zeros_q;
    valid_d   = 1'b0;
    data_d    = 1'b0;
    active_d  = rx_active;
    eop_d     = 1'b0;
    err_d     = 1'b0;
    bit_dec   = (d == level_q);
    k_edge    = (d != d_q) && !se0 && (d == LINE_K);
    ones_full = (ones_q == OW'(STUFF_LEN));
    if (strobe)
      level_d = d;
    if (!en) begin
      state_d  = IDLE;
      ones_d   = '0;
      zeros_d  = '0;
      active_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          active_d = 1'b0;
          if (k_edge) begin
            state_d = SYNC;
            zeros_d = '0;
          end
        end
        SYNC: begin
          active_d = 1'b0;
          if (strobe) begin
            if (se0) begin
              state_d = IDLE;
            end else if (!bit_dec) begin
              if (zeros_q != ZW'(SYNC_MIN_ZEROS))
                zeros_d = zeros_q + ZW'(1);
            end else if (zeros_q >= ZW'(SYNC_MIN_ZEROS)) begin
              state_d = DATA;
              ones_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          if (strobe) begin
            if (se0) begin
              state_d = EOP;
            end else if (bit_dec && ones_full) begin
              err_d    = 1'b1;
              active_d = 1'b0;
              state_d  = IDLE;
            end else if (bit_dec) begin
              ones_d   = ones_q + OW'(1);
              valid_d  = 1'b1;
              data_d   = 1'b1;
              active_d = 1'b1;
            end else if (ones_full) begin
              ones_d = '0;
            end else begin
              ones_d   = '0;
              valid_d  = 1'b1;
              active_d = 1'b1;
            end
          end
        end
        EOP: begin
          if (strobe && !se0) begin
            state_d  = IDLE;
            active_d = 1'b0;
            if (d == LINE_J)
              eop_d = 1'b1;
            else
              err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      level_q   <= LINE_J;
      d_q       <= LINE_J;
      ones_q    <= '0;
      zeros_q   <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= 1'b0;
      rx_active <= 1'b0;
      eop       <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      d_q       <= d;
      ones_q    <= ones_d;
      zeros_q   <= zeros_d;
      rx_valid  <= valid_d;
      rx_data   <= data_d;
      rx_active <= active_d;
      eop       <= eop_d;
      rx_error  <= err_d;
    end
  end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder.
// NRZI line driver plus negedge output monitor.
module tb_usb_rx_decoder;
  import usb_rx_decoder_pkg::*;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic d = 1'b1;
  logic se0 = 1'b0;
  logic rx_valid, rx_data, rx_active, eop, rx_error;

  int checks = 0;
  int errors = 0;
  int nval = 0;
  int neop = 0;
  int nerr = 0;
  int nact_bad = 0;
  logic [31:0] rxv = '0;
  logic tx_lvl = 1'b1;

  always #5 clk = ~clk;

  usb_rx_decoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .d        (d),
    .se0      (se0),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_active(rx_active),
    .eop      (eop),
    .rx_error (rx_error)
  );

  // Collect emitted bits and pulses.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (nval < 32) rxv[nval] = rx_data;
      nval++;
      if (!rx_active) nact_bad++;
    end
    if (eop) neop++;
    if (rx_error) nerr++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic lvl, input logic s, input int n);
    d = lvl;
    se0 = s;
    repeat (n) tick();
  endtask

  function automatic int off(input int k);
    if (k % 8 == 1) return 1;
    if (k % 8 == 5) return -1;
    return 0;
  endfunction

  task automatic tx(input logic b, input int n);
    if (!b) tx_lvl = ~tx_lvl;
    hold(tx_lvl, 1'b0, n);
  endtask

  task automatic send(input logic [31:0] bits, input int nb, input bit jit);
    for (int i = 0; i < nb; i++)
      tx(bits[i], jit ? CPB + off(i + 1) - off(i) : CPB);
  endtask

  task automatic mon_clr();
    nval = 0;
    neop = 0;
    nerr = 0;
    nact_bad = 0;
    rxv = '0;
  endtask

  task automatic finish_pkt(input bit bad);
    hold(1'b0, 1'b1, 2 * CPB);
    if (bad) hold(LINE_K, 1'b0, CPB);
    hold(LINE_J, 1'b0, 6 * CPB);
    tx_lvl = LINE_J;
  endtask

  task automatic expect_pkt(input string tag, input int nv,
                            input logic [31:0] v, input int ne,
                            input int nr);
    chk({tag, ".nval"}, nval, nv);
    chk({tag, ".data"}, rxv, v);
    chk({tag, ".eop"}, neop, ne);
    chk({tag, ".err"}, nerr, nr);
    chk({tag, ".act"}, {nact_bad[30:0], rx_active}, 0);
  endtask

  task automatic pkt(input string tag, input logic [31:0] bits,
                     input int nb, input bit jit, input bit bad,
                     input int nv, input logic [31:0] v,
                     input int ne, input int nr);
    mon_clr();
    send(bits, nb, jit);
    finish_pkt(bad);
    expect_pkt(tag, nv, v, ne, nr);
  endtask

  initial begin
    hold(LINE_J, 1'b0, 3);
    chk("rst.valid", rx_valid, 0);
    chk("rst.data", rx_data, 0);
    chk("rst.active", rx_active, 0);
    chk("rst.eop", eop, 0);
    chk("rst.err", rx_error, 0);
    rst_n = 1'b1;
    en = 1'b1;
    hold(LINE_J, 1'b0, 8 * CPB);

    pkt("clean", 32'hA580, 16, 0, 0, 8, 32'hA5, 1, 0);
    pkt("stuff", 32'h1BF80, 17, 0, 0, 8, 32'hFF, 1, 0);
    pkt("stferr", 32'h7F80, 15, 0, 0, 6, 32'h3F, 0, 1);
    pkt("jitter", 32'hA580, 16, 1, 0, 8, 32'hA5, 1, 0);
    pkt("badeop", 32'hA580, 16, 0, 1, 8, 32'hA5, 0, 1);
    pkt("sync4", 32'hA58, 12, 0, 0, 8, 32'hA5, 1, 0);
    pkt("sync2", 32'h4, 3, 0, 0, 0, 32'h0, 0, 0);

    send(32'hA580, 12, 0);
    chk("aen.pre", rx_active, 1);
    en = 1'b0;
    tick();
    chk("aen.outs", {rx_valid, rx_data, rx_active, eop, rx_error}, 0);
    mon_clr();
    en = 1'b1;
    hold(LINE_J, 1'b0, 8 * CPB);
    tx_lvl = LINE_J;
    chk("aen.post", {nval[15:0], neop[7:0], nerr[7:0]}, 0);
    pkt("aen.next", 32'hA580, 16, 0, 0, 8, 32'hA5, 1, 0);

    send(32'hA580, 12, 0);
    chk("arst.pre", rx_active, 1);
    rst_n = 1'b0;
    tick();
    chk("arst.outs", {rx_valid, rx_data, rx_active, eop, rx_error}, 0);
    mon_clr();
    rst_n = 1'b1;
    hold(LINE_J, 1'b0, 8 * CPB);
    tx_lvl = LINE_J;
    chk("arst.post", {nval[15:0], neop[7:0], nerr[7:0]}, 0);
    pkt("arst.next", 32'hA580, 16, 0, 0, 8, 32'hA5, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
